decode_stage: RTL and testbench

- Pipeline ID stage of the MIPS core: IF/ID register, instruction field extraction, main and ALU control decode, sign extension and operand-ready scoreboard check.
- Drives the register file read indices and consumes its read data and ready flags.
- Issues one instruction per cycle into an internal ID/EX register.
- Emits a one-cycle claim pulse so the register file can clear the destination's ready flag.

---
 rtl/decode_stage.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// MIPS ID stage: IF/ID register, main/ALU decode, operand scoreboard check and
// ID/EX register, with a destination-claim pulse back to the register file.
module decode_stage #(
    parameter int STALL_CNT_W    = 16,
    parameter bit USE_SCOREBOARD = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [31:0]            instrF,
    input  logic [31:0]            pcPlus4F,
    input  logic                   validF,
    input  logic                   stallE,
    input  logic                   flushD,
    output logic                   stallF,
    output logic [4:0]             index1,
    output logic [4:0]             index2,
    input  logic [31:0]            valueOutput1,
    input  logic [31:0]            valueOutput2,
    input  logic                   flagOutput1,
    input  logic                   flagOutput2,
    output logic                   claimValid,
    output logic [4:0]             claimIndex,
    output logic                   validE,
    output logic                   regWriteE,
    output logic                   memToRegE,
    output logic                   memWriteE,
    output logic                   aluSrcE,
    output logic                   regDstE,
    output logic                   branchE,
    output logic                   jumpE,
    output logic [2:0]             aluControlE,
    output logic [31:0]            rd1E,
    output logic [31:0]            rd2E,
    output logic [31:0]            immExtE,
    output logic [4:0]             RsE,
    output logic [4:0]             RtE,
    output logic [4:0]             RdE,
    output logic [31:0]            pcPlus4E,
    output logic                   illegalE,
    output logic [STALL_CNT_W-1:0] stallCount
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic        alu_src;
        logic        reg_dst;
        logic        branch;
        logic        jump;
        logic        illegal;
        logic [2:0]  alu_ctl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } idex_t;

    state_t                 state_q, state_d, cur_state;
    logic [31:0]            instr_q, instr_d;
    logic [31:0]            pc4_q, pc4_d;
    idex_t                  idex_q, idex_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, dest;
    logic [31:0] imm_ext;
    logic        dec_reg_write, dec_mem_to_reg, dec_mem_write, dec_alu_src;
    logic        dec_reg_dst, dec_branch, dec_jump, dec_illegal;
    logic [2:0]  dec_alu_ctl;
    logic        use_rs, use_rt, rs_ready, rt_ready, operands_ready;
    logic        idex_issue, idex_bubble, stall_f, claim;
    logic        unused_shamt;

    assign op      = instr_q[31:26];
    assign rs      = instr_q[25:21];
    assign rt      = instr_q[20:16];
    assign rd      = instr_q[15:11];
    assign funct   = instr_q[5:0];
    assign imm_ext = {{16{instr_q[15]}}, instr_q[15:0]};
    assign unused_shamt = ^instr_q[10:6];

    always_comb begin
        dec_reg_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_mem_write  = 1'b0;
        dec_alu_src    = 1'b0;
        dec_reg_dst    = 1'b0;
        dec_branch     = 1'b0;
        dec_jump       = 1'b0;
        dec_illegal    = 1'b0;
        dec_alu_ctl    = ALU_AND;
        use_rs         = 1'b0;
        use_rt         = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  dec_alu_ctl = ALU_ADD;
                    FN_SUB:  dec_alu_ctl = ALU_SUB;
                    FN_AND:  dec_alu_ctl = ALU_AND;
                    FN_OR:   dec_alu_ctl = ALU_OR;
                    FN_SLT:  dec_alu_ctl = ALU_SLT;
                    default: dec_illegal = 1'b1;
                endcase
                // An unknown funct issues as a NOP, so it neither writes nor waits on sources
                if (!dec_illegal) begin
                    dec_reg_write = 1'b1;
                    dec_reg_dst   = 1'b1;
                    use_rs        = 1'b1;
                    use_rt        = 1'b1;
                end else begin
                    dec_alu_ctl = ALU_AND;
                end
            end
            OP_LW: begin
                dec_reg_write  = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_alu_src    = 1'b1;
                dec_alu_ctl    = ALU_ADD;
                use_rs         = 1'b1;
            end
            OP_SW: begin
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_ctl   = ALU_ADD;
                use_rs        = 1'b1;
                use_rt        = 1'b1;
            end
            OP_BEQ: begin
                dec_branch  = 1'b1;
                dec_alu_ctl = ALU_SUB;
                use_rs      = 1'b1;
                use_rt      = 1'b1;
            end
            OP_ADDI: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_ctl   = ALU_ADD;
                use_rs        = 1'b1;
            end
            OP_J: begin
                dec_jump = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign dest     = dec_reg_dst ? rd : rt;
    assign rs_ready = (rs == 5'd0) || flagOutput1;
    assign rt_ready = (rt == 5'd0) || flagOutput2;

    always_comb begin
        if (USE_SCOREBOARD == 1'b0) begin
            operands_ready = 1'b1;
        end else begin
            operands_ready = (!use_rs || rs_ready) && (!use_rt || rt_ready);
        end
    end

    // The registered state only records occupancy; readiness is re-judged every cycle
    always_comb begin
        if (state_q == ST_EMPTY) begin
            cur_state = ST_EMPTY;
        end else if (operands_ready) begin
            cur_state = ST_ISSUE;
        end else begin
            cur_state = ST_WAIT;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        pc4_d       = pc4_q;
        cnt_d       = cnt_q;
        idex_issue  = 1'b0;
        idex_bubble = 1'b0;
        stall_f     = 1'b0;
        claim       = 1'b0;
        if (flushD) begin
            state_d     = ST_EMPTY;
            idex_bubble = 1'b1;
        end else if (stallE) begin
            stall_f = 1'b1;
        end else begin
            case (cur_state)
                ST_ISSUE: begin
                    state_d    = validF ? ST_ISSUE : ST_EMPTY;
                    instr_d    = instrF;
                    pc4_d      = pcPlus4F;
                    idex_issue = 1'b1;
                    claim      = dec_reg_write && (dest != 5'd0);
                end
                ST_WAIT: begin
                    state_d     = ST_WAIT;
                    stall_f     = 1'b1;
                    idex_bubble = 1'b1;
                    cnt_d       = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                end
                default: begin
                    state_d     = validF ? ST_ISSUE : ST_EMPTY;
                    instr_d     = instrF;
                    pc4_d       = pcPlus4F;
                    idex_bubble = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        idex_d = idex_q;
        if (idex_bubble) begin
            idex_d = '0;
        end else if (idex_issue) begin
            idex_d.valid      = 1'b1;
            idex_d.reg_write  = dec_reg_write;
            idex_d.mem_to_reg = dec_mem_to_reg;
            idex_d.mem_write  = dec_mem_write;
            idex_d.alu_src    = dec_alu_src;
            idex_d.reg_dst    = dec_reg_dst;
            idex_d.branch     = dec_branch;
            idex_d.jump       = dec_jump;
            idex_d.illegal    = dec_illegal;
            idex_d.alu_ctl    = dec_alu_ctl;
            idex_d.rd1        = valueOutput1;
            idex_d.rd2        = valueOutput2;
            idex_d.imm        = imm_ext;
            idex_d.pc4        = pc4_q;
            idex_d.rs         = rs;
            idex_d.rt         = rt;
            idex_d.rd         = rd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
            instr_q <= '0;
            pc4_q   <= '0;
            idex_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            idex_q  <= idex_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stallF      = stall_f;
    assign index1      = rs;
    assign index2      = rt;
    assign claimValid  = claim;
    assign claimIndex  = dest;
    assign validE      = idex_q.valid;
    assign regWriteE   = idex_q.reg_write;
    assign memToRegE   = idex_q.mem_to_reg;
    assign memWriteE   = idex_q.mem_write;
    assign aluSrcE     = idex_q.alu_src;
    assign regDstE     = idex_q.reg_dst;
    assign branchE     = idex_q.branch;
    assign jumpE       = idex_q.jump;
    assign aluControlE = idex_q.alu_ctl;
    assign rd1E        = idex_q.rd1;
    assign rd2E        = idex_q.rd2;
    assign immExtE     = idex_q.imm;
    assign RsE         = idex_q.rs;
    assign RtE         = idex_q.rt;
    assign RdE         = idex_q.rd;
    assign pcPlus4E    = idex_q.pc4;
    assign illegalE    = idex_q.illegal;
    assign stallCount  = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a default instance plus a 2-bit stall
// counter instance sharing the same stimulus, checked with immediate assertions.
module tb_decode_stage;

    localparam logic [31:0] I_ADD  = 32'h00221820;  // add  $3,$1,$2
    localparam logic [31:0] I_ADDI = 32'h20040005;  // addi $4,$0,5
    localparam logic [31:0] I_SUB  = 32'h00002822;  // sub  $5,$0,$0
    localparam logic [31:0] I_SW   = 32'hAC200004;  // sw   $0,4($1)
    localparam logic [31:0] I_BEQ  = 32'h1022FFFF;  // beq  $1,$2,-1
    localparam logic [31:0] I_LW   = 32'h8C460008;  // lw   $6,8($2)
    localparam logic [31:0] I_ILL  = 32'hFC000000;  // opcode 0x3F

    logic        clk;
    logic        reset_n;
    logic [31:0] instrF, pcPlus4F, valueOutput1, valueOutput2;
    logic        validF, stallE, flushD, flagOutput1, flagOutput2;

    logic        stallF, claimValid, validE, regWriteE, memToRegE, memWriteE;
    logic        aluSrcE, regDstE, branchE, jumpE, illegalE;
    logic [4:0]  index1, index2, claimIndex, RsE, RtE, RdE;
    logic [2:0]  aluControlE;
    logic [31:0] rd1E, rd2E, immExtE, pcPlus4E;
    logic [15:0] stallCount;

    logic        s_stallF, s_claimValid, s_validE, s_regWriteE, s_memToRegE, s_memWriteE;
    logic        s_aluSrcE, s_regDstE, s_branchE, s_jumpE, s_illegalE;
    logic [4:0]  s_index1, s_index2, s_claimIndex, s_RsE, s_RtE, s_RdE;
    logic [2:0]  s_aluControlE;
    logic [31:0] s_rd1E, s_rd2E, s_immExtE, s_pcPlus4E;
    logic [1:0]  s_stallCount;

    int testsRun    = 0;
    int testsFailed = 0;

    decode_stage u_dut (
        .clk(clk), .reset_n(reset_n), .instrF(instrF), .pcPlus4F(pcPlus4F),
        .validF(validF), .stallE(stallE), .flushD(flushD), .stallF(stallF),
        .index1(index1), .index2(index2), .valueOutput1(valueOutput1),
        .valueOutput2(valueOutput2), .flagOutput1(flagOutput1), .flagOutput2(flagOutput2),
        .claimValid(claimValid), .claimIndex(claimIndex), .validE(validE),
        .regWriteE(regWriteE), .memToRegE(memToRegE), .memWriteE(memWriteE),
        .aluSrcE(aluSrcE), .regDstE(regDstE), .branchE(branchE), .jumpE(jumpE),
        .aluControlE(aluControlE), .rd1E(rd1E), .rd2E(rd2E), .immExtE(immExtE),
        .RsE(RsE), .RtE(RtE), .RdE(RdE), .pcPlus4E(pcPlus4E), .illegalE(illegalE),
        .stallCount(stallCount)
    );

    decode_stage #(.STALL_CNT_W(2)) u_sat (
        .clk(clk), .reset_n(reset_n), .instrF(instrF), .pcPlus4F(pcPlus4F),
        .validF(validF), .stallE(stallE), .flushD(flushD), .stallF(s_stallF),
        .index1(s_index1), .index2(s_index2), .valueOutput1(valueOutput1),
        .valueOutput2(valueOutput2), .flagOutput1(flagOutput1), .flagOutput2(flagOutput2),
        .claimValid(s_claimValid), .claimIndex(s_claimIndex), .validE(s_validE),
        .regWriteE(s_regWriteE), .memToRegE(s_memToRegE), .memWriteE(s_memWriteE),
        .aluSrcE(s_aluSrcE), .regDstE(s_regDstE), .branchE(s_branchE), .jumpE(s_jumpE),
        .aluControlE(s_aluControlE), .rd1E(s_rd1E), .rd2E(s_rd2E), .immExtE(s_immExtE),
        .RsE(s_RsE), .RtE(s_RtE), .RdE(s_RdE), .pcPlus4E(s_pcPlus4E), .illegalE(s_illegalE),
        .stallCount(s_stallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic valid,
                                 input logic f1, input logic f2);
        instrF      = instr;
        pcPlus4F    = pcPlus4F + 32'd4;
        validF      = valid;
        flagOutput1 = f1;
        flagOutput2 = f2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        instrF = '0; pcPlus4F = '0; validF = 1'b0; stallE = 1'b0; flushD = 1'b0;
        valueOutput1 = '0; valueOutput2 = '0; flagOutput1 = 1'b1; flagOutput2 = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        mid();
        checkOutput("rst_validE", 32'(validE), 32'd0);
        checkOutput("rst_stallF", 32'(stallF), 32'd0);
        checkOutput("rst_stallCount", 32'(stallCount), 32'd0);
        checkOutput("rst_claimValid", 32'(claimValid), 32'd0);

        // back-to-back independent instructions
        tick();
        valueOutput1 = 32'h11; valueOutput2 = 32'h22;
        applyStimulus(I_ADD, 1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(I_ADDI, 1'b1, 1'b1, 1'b1);
        mid();
        checkOutput("b2b_claim_add", 32'(claimValid), 32'd1);
        checkOutput("b2b_claimIdx_add", 32'(claimIndex), 32'd3);
        checkOutput("b2b_index1", 32'(index1), 32'd1);
        checkOutput("b2b_index2", 32'(index2), 32'd2);
        tick();
        applyStimulus(32'd0, 1'b0, 1'b1, 1'b1);
        mid();
        checkOutput("b2b_validE_add", 32'(validE), 32'd1);
        checkOutput("b2b_aluCtl_add", 32'(aluControlE), 32'd2);
        checkOutput("b2b_rd1E", rd1E, 32'h11);
        checkOutput("b2b_rd2E", rd2E, 32'h22);
        checkOutput("b2b_RdE", 32'(RdE), 32'd3);
        checkOutput("b2b_claim_addi", 32'(claimValid), 32'd1);
        checkOutput("b2b_claimIdx_addi", 32'(claimIndex), 32'd4);
        tick();
        mid();
        checkOutput("b2b_validE_addi", 32'(validE), 32'd1);
        checkOutput("b2b_immExt_addi", immExtE, 32'd5);
        checkOutput("b2b_aluSrc_addi", 32'(aluSrcE), 32'd1);
        checkOutput("b2b_RtE_addi", 32'(RtE), 32'd4);
        checkOutput("b2b_claim_empty", 32'(claimValid), 32'd0);

        // RAW stall on rs for three cycles
        tick();
        applyStimulus(I_ADD, 1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(I_SUB, 1'b1, 1'b0, 1'b1);
        mid();
        checkOutput("raw_stallF", 32'(stallF), 32'd1);
        checkOutput("raw_noclaim", 32'(claimValid), 32'd0);
        tick();
        mid();
        checkOutput("raw_bubble", 32'(validE), 32'd0);
        checkOutput("raw_stallF_hold", 32'(stallF), 32'd1);
        tick();
        tick();
        valueOutput1 = 32'h55;
        flagOutput1  = 1'b1;
        mid();
        checkOutput("raw_stallCount", 32'(stallCount), 32'd3);
        checkOutput("raw_validE_still0", 32'(validE), 32'd0);
        checkOutput("raw_release_stallF", 32'(stallF), 32'd0);
        checkOutput("raw_claim", 32'(claimValid), 32'd1);
        checkOutput("raw_claimIdx", 32'(claimIndex), 32'd3);
        tick();
        applyStimulus(32'd0, 1'b0, 1'b0, 1'b0);
        mid();
        checkOutput("raw_issue_validE", 32'(validE), 32'd1);
        checkOutput("raw_issue_rd1E", rd1E, 32'h55);
        checkOutput("zero_src_nostall", 32'(stallF), 32'd0);
        checkOutput("zero_src_claim", 32'(claimValid), 32'd1);
        checkOutput("zero_src_claimIdx", 32'(claimIndex), 32'd5);
        tick();
        mid();
        checkOutput("sub_aluCtl", 32'(aluControlE), 32'd6);
        checkOutput("sub_RdE", 32'(RdE), 32'd5);
        checkOutput("sub_stallCount", 32'(stallCount), 32'd3);

        // sw, beq and an illegal opcode back to back
        tick();
        applyStimulus(I_SW, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(I_BEQ, 1'b1, 1'b1, 1'b1);
        mid();
        checkOutput("sw_noclaim", 32'(claimValid), 32'd0);
        checkOutput("sw_nostall", 32'(stallF), 32'd0);
        tick();
        applyStimulus(I_ILL, 1'b1, 1'b1, 1'b1);
        mid();
        checkOutput("sw_memWrite", 32'(memWriteE), 32'd1);
        checkOutput("sw_regWrite", 32'(regWriteE), 32'd0);
        checkOutput("sw_immExt", immExtE, 32'd4);
        tick();
        applyStimulus(32'd0, 1'b0, 1'b1, 1'b1);
        mid();
        checkOutput("beq_branch", 32'(branchE), 32'd1);
        checkOutput("beq_aluCtl", 32'(aluControlE), 32'd6);
        checkOutput("beq_immExt_neg", immExtE, 32'hFFFF_FFFF);
        checkOutput("ill_noclaim", 32'(claimValid), 32'd0);
        tick();
        mid();
        checkOutput("ill_validE", 32'(validE), 32'd1);
        checkOutput("ill_illegalE", 32'(illegalE), 32'd1);
        checkOutput("ill_controls",
                    32'({regWriteE, memToRegE, memWriteE, aluSrcE, regDstE,
                         branchE, jumpE, aluControlE}), 32'd0);

        // downstream back-pressure holds both pipeline registers
        tick();
        applyStimulus(I_ADDI, 1'b1, 1'b1, 1'b1);
        tick();
        valueOutput1 = 32'h100;
        applyStimulus(I_LW, 1'b1, 1'b1, 1'b1);
        tick();
        stallE = 1'b1;
        mid();
        checkOutput("stallE_stallF", 32'(stallF), 32'd1);
        checkOutput("stallE_noclaim", 32'(claimValid), 32'd0);
        tick();
        mid();
        checkOutput("stallE_hold_validE", 32'(validE), 32'd1);
        checkOutput("stallE_hold_imm", immExtE, 32'd5);
        checkOutput("stallE_hold_RtE", 32'(RtE), 32'd4);
        checkOutput("stallE_count", 32'(stallCount), 32'd3);
        tick();
        stallE = 1'b0;
        applyStimulus(32'd0, 1'b0, 1'b1, 1'b1);
        mid();
        checkOutput("lw_claim", 32'(claimValid), 32'd1);
        checkOutput("lw_claimIdx", 32'(claimIndex), 32'd6);
        tick();
        mid();
        checkOutput("lw_validE", 32'(validE), 32'd1);
        checkOutput("lw_memToReg", 32'(memToRegE), 32'd1);
        checkOutput("lw_immExt", immExtE, 32'd8);
        checkOutput("lw_RtE", 32'(RtE), 32'd6);
        checkOutput("lw_rd1E", rd1E, 32'h100);

        // flush while waiting on an operand
        tick();
        applyStimulus(I_ADD, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(32'd0, 1'b0, 1'b0, 1'b1);
        flushD = 1'b1;
        mid();
        checkOutput("flush_noclaim", 32'(claimValid), 32'd0);
        tick();
        flushD      = 1'b0;
        flagOutput1 = 1'b1;
        mid();
        checkOutput("flush_validE", 32'(validE), 32'd0);
        checkOutput("flush_stallF", 32'(stallF), 32'd0);
        checkOutput("flush_empty_noclaim", 32'(claimValid), 32'd0);
        checkOutput("flush_count_frozen", 32'(stallCount), 32'd3);
        tick();
        mid();
        checkOutput("flush_no_late_issue", 32'(validE), 32'd0);

        // asynchronous reset mid-stream while stalled
        tick();
        applyStimulus(I_ADDI, 1'b1, 1'b1, 1'b1);
        tick();
        applyStimulus(I_ADD, 1'b1, 1'b0, 1'b1);
        tick();
        mid();
        checkOutput("pre_rst_validE", 32'(validE), 32'd1);
        checkOutput("pre_rst_stallF", 32'(stallF), 32'd1);
        tick();
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_validE", 32'(validE), 32'd0);
        checkOutput("async_rst_stallF", 32'(stallF), 32'd0);
        checkOutput("async_rst_stallCount", 32'(stallCount), 32'd0);
        checkOutput("async_rst_claim", 32'(claimValid), 32'd0);
        #1 reset_n = 1'b1;

        // six stall cycles: 16-bit counter reads 6, 2-bit counter saturates at 3
        tick();
        repeat (6) tick();
        mid();
        checkOutput("sat_wide_count", 32'(stallCount), 32'd6);
        checkOutput("sat_narrow_count", 32'(s_stallCount), 32'd3);
        checkOutput("sat_stallF", 32'(stallF), 32'd1);
        checkOutput("sat_validE", 32'(validE), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
